// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage: sequencer, HI/LO registers
// and the stall request the hazard unit uses for D-stage MDU instructions.
module mdu_ctrl #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  mdu_op,
   input  logic        op_valid,
   input  logic        exc_cancel,
   input  logic [31:0] rs_val,
   input  logic [31:0] rt_val,
   input  logic        D_md_use,
   output logic        start,
   output logic        busy,
   output logic        mdu_stall,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] mdu_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);
   localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);

   typedef enum logic {IDLE, RUN} state_t;

   state_t        state, state_next;
   logic [CW-1:0] count;
   logic [31:0]   pend_hi, pend_lo;
   logic          pend_wr;

   logic          issue, is_arith, done;
   logic [63:0]   prod_s, prod_u;
   logic [31:0]   dvd, dvs, q_mag, r_mag;
   logic [31:0]   res_hi, res_lo;
   logic          res_wr;

   assign issue     = op_valid && !exc_cancel && (state == IDLE);
   assign is_arith  = (mdu_op >= 4'd1) && (mdu_op <= 4'd4);
   assign start     = issue && is_arith;
   assign done      = (state == RUN) && (count == CW'(1));
   assign mdu_stall = D_md_use && (start || busy);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start) state_next = RUN;
         RUN:     if (done)  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Signed division works on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
   always_comb begin
      prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
      prod_u = {32'd0, rs_val} * {32'd0, rt_val};
      dvd    = (mdu_op == 4'd3 && rs_val[31]) ? -rs_val : rs_val;
      dvs    = (mdu_op == 4'd3 && rt_val[31]) ? -rt_val : rt_val;
      if (rt_val == 32'd0) dvs = 32'd1;
      q_mag  = dvd / dvs;
      r_mag  = dvd % dvs;
      res_hi = 32'd0;
      res_lo = 32'd0;
      res_wr = 1'b1;
      case (mdu_op)
         4'd1: begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
         4'd2: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
         4'd3: begin
            res_lo = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
            res_hi = rs_val[31] ? -r_mag : r_mag;
            res_wr = (rt_val != 32'd0);
         end
         4'd4: begin
            res_lo = q_mag;
            res_hi = r_mag;
            res_wr = (rt_val != 32'd0);
         end
         default: ;
      endcase
   end

   // Result is captured at start; HI/LO only change on completion or mthi/mtlo in IDLE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy    <= 1'b0;
         count   <= '0;
         hi      <= 32'd0;
         lo      <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_wr <= 1'b0;
      end else begin
         if (start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_wr <= res_wr;
            count   <= (mdu_op <= 4'd2) ? MULT_LOAD : DIV_LOAD;
            busy    <= 1'b1;
         end else if (state == RUN) begin
            count <= count - 1'b1;
            if (done) begin
               busy <= 1'b0;
               if (pend_wr) begin
                  hi <= pend_hi;
                  lo <= pend_lo;
               end
            end
         end
         if (issue && mdu_op == 4'd7) hi <= rs_val;
         if (issue && mdu_op == 4'd8) lo <= rs_val;
      end
   end

   always_comb begin
      case (mdu_op)
         4'd5:    mdu_out = hi;
         4'd6:    mdu_out = lo;
         default: mdu_out = 32'd0;
      endcase
   end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed scoreboard bench for mdu_ctrl: stimulus pushes expected HI/LO and
// busy length, a negedge monitor pops and compares whenever busy drops.
module tb_mdu_ctrl;

   logic        clk;
   logic        reset;
   logic [3:0]  mdu_op;
   logic        op_valid;
   logic        exc_cancel;
   logic [31:0] rs_val;
   logic [31:0] rt_val;
   logic        D_md_use;
   logic        start;
   logic        busy;
   logic        mdu_stall;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] mdu_out;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          cycles;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_fails  = 0;
   int   busy_cnt = 0;
   logic prev_busy = 1'b0;

   mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .mdu_op(mdu_op), .op_valid(op_valid),
      .exc_cancel(exc_cancel), .rs_val(rs_val), .rt_val(rt_val),
      .D_md_use(D_md_use), .start(start), .busy(busy), .mdu_stall(mdu_stall),
      .hi(hi), .lo(lo), .mdu_out(mdu_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: a falling busy marks a completed operation.
   always @(negedge clk) begin
      if (!reset) begin
         prev_busy = 1'b0;
         busy_cnt  = 0;
      end else begin
         if (busy) busy_cnt++;
         else if (prev_busy) begin
            if (sb.size() == 0) begin
               n_checks++;
               n_fails++;
               $display("[TB] FAIL sb_empty: completion seen with no expected entry");
            end else begin
               exp_t e;
               e = sb.pop_front();
               check_output("sb_hi", hi, e.hi);
               check_output("sb_lo", lo, e.lo);
               check_output("sb_busy_cycles", 32'(busy_cnt), 32'(e.cycles));
            end
            busy_cnt = 0;
         end
         prev_busy = busy;
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                                 input logic cancel);
      mdu_op     = op;
      op_valid   = 1'b1;
      exc_cancel = cancel;
      rs_val     = rs;
      rt_val     = rt;
   endtask

   task automatic clear_stimulus();
      mdu_op     = 4'd0;
      op_valid   = 1'b0;
      exc_cancel = 1'b0;
      rs_val     = 32'd0;
      rt_val     = 32'd0;
   endtask

   task automatic start_mdu(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                            input logic [31:0] ehi, input logic [31:0] elo, input int n);
      sb.push_back('{hi: ehi, lo: elo, cycles: n});
      D_md_use = 1'b1;
      apply_stimulus(op, rs, rt, 1'b0);
      @(negedge clk);
      check_output("start_pulse", 32'(start), 32'd1);
      check_output("stall_on_start", 32'(mdu_stall), 32'd1);
      next_cycle();
      clear_stimulus();
   endtask

   task automatic wait_done();
      bit seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!busy) begin
            seen = 1'b1;
            break;
         end
         check_output("stall_while_busy", 32'(mdu_stall), 32'(D_md_use));
      end
      if (!seen) begin
         n_checks++;
         n_fails++;
         $display("[TB] FAIL busy_timeout: busy=%0b, expected 0 within 40 cycles", busy);
      end
      check_output("stall_after_done", 32'(mdu_stall), 32'd0);
      D_md_use = 1'b0;
      next_cycle();
   endtask

   task automatic move_to(input logic [3:0] op, input logic [31:0] val);
      apply_stimulus(op, val, 32'd0, 1'b0);
      next_cycle();
      clear_stimulus();
   endtask

   initial begin
      reset    = 1'b0;
      D_md_use = 1'b0;
      clear_stimulus();
      @(negedge clk);
      check_output("reset_busy", 32'(busy), 32'd0);
      check_output("reset_hi", hi, 32'd0);
      check_output("reset_lo", lo, 32'd0);
      next_cycle();
      reset = 1'b1;
      next_cycle();

      // mult -3 * 5 = -15
      start_mdu(4'd1, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 5);
      @(negedge clk);
      check_output("busy_after_start", 32'(busy), 32'd1);
      check_output("start_one_cycle", 32'(start), 32'd0);
      wait_done();

      start_mdu(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      wait_done();
      start_mdu(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
      wait_done();
      start_mdu(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 10);
      wait_done();

      // Divide by zero keeps HI/LO
      move_to(4'd7, 32'h11);
      move_to(4'd8, 32'h22);
      @(negedge clk);
      check_output("mthi_value", hi, 32'h11);
      check_output("mtlo_value", lo, 32'h22);
      next_cycle();
      start_mdu(4'd3, 32'd5, 32'd0, 32'h11, 32'h22, 10);
      wait_done();
      apply_stimulus(4'd5, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check_output("mfhi_out", mdu_out, 32'h11);
      check_output("mfhi_no_start", 32'(start), 32'd0);
      next_cycle();
      apply_stimulus(4'd6, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check_output("mflo_out", mdu_out, 32'h22);
      next_cycle();
      apply_stimulus(4'd9, 32'd0, 32'd0, 1'b0);
      @(negedge clk);
      check_output("op9_no_start", 32'(start), 32'd0);
      check_output("op9_out_zero", mdu_out, 32'd0);
      next_cycle();

      // exc_cancel suppression
      apply_stimulus(4'd7, 32'hABCD, 32'd0, 1'b1);
      @(negedge clk);
      check_output("mthi_cancel_start", 32'(start), 32'd0);
      next_cycle();
      clear_stimulus();
      @(negedge clk);
      check_output("mthi_cancel_hi", hi, 32'h11);
      next_cycle();
      move_to(4'd7, 32'hABCD);
      @(negedge clk);
      check_output("mthi_hi", hi, 32'hABCD);
      next_cycle();
      D_md_use = 1'b1;
      apply_stimulus(4'd1, 32'd3, 32'd3, 1'b1);
      @(negedge clk);
      check_output("mult_cancel_start", 32'(start), 32'd0);
      check_output("mult_cancel_stall", 32'(mdu_stall), 32'd0);
      next_cycle();
      clear_stimulus();
      D_md_use = 1'b0;
      @(negedge clk);
      check_output("mult_cancel_busy", 32'(busy), 32'd0);
      next_cycle();

      // Cancel and mtlo during RUN must not disturb the running multu
      start_mdu(4'd2, 32'hFFFFFFFF, 32'd2, 32'd1, 32'hFFFFFFFE, 5);
      D_md_use = 1'b0;
      exc_cancel = 1'b1;
      next_cycle();
      exc_cancel = 1'b0;
      apply_stimulus(4'd8, 32'h5555, 32'd0, 1'b0);
      @(negedge clk);
      check_output("run_mtlo_start", 32'(start), 32'd0);
      next_cycle();
      clear_stimulus();
      @(negedge clk);
      check_output("run_mtlo_lo", lo, 32'h22);
      check_output("run_stall_no_d", 32'(mdu_stall), 32'd0);
      wait_done();

      // Asynchronous reset mid-divide
      start_mdu(4'd3, 32'd50, 32'd3, 32'd2, 32'd16, 10);
      repeat (3) next_cycle();
      reset = 1'b0;
      #1;
      check_output("async_reset_busy", 32'(busy), 32'd0);
      check_output("async_reset_hi", hi, 32'd0);
      check_output("async_reset_lo", lo, 32'd0);
      sb.delete();
      D_md_use = 1'b0;
      next_cycle();
      reset = 1'b1;
      repeat (15) next_cycle();
      @(negedge clk);
      check_output("no_late_hi", hi, 32'd0);
      check_output("no_late_lo", lo, 32'd0);
      check_output("no_late_busy", 32'(busy), 32'd0);
      check_output("sb_drained", 32'(sb.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide unit with its sequencer and HI/LO registers. Sits in the E stage.
- Takes the 4-bit MDU operation code from the E-stage control word plus forwarded rs/rt values, and runs mult/multu/div/divu over a fixed number of cycles.
- Writes HI/LO on completion, services mthi/mtlo/mfhi/mflo, and gives the hazard unit a stall request for D-stage MDU instructions while the unit is occupied.

Parameters:
- MULT_CYCLES, 5, busy duration of mult/multu (>=1)
- DIV_CYCLES, 10, busy duration of div/divu (>=1)

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state immediately
- mdu_op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 treated as none
- op_valid  input  1  E-stage instruction is valid (not a bubble/flushed)
- exc_cancel  input  1  exception/interrupt taken this cycle; E-stage MDU instruction must not take effect
- rs_val  input  32  forwarded rs operand
- rt_val  input  32  forwarded rt operand
- D_md_use  input  1  D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
- start  output  1  combinational: op_valid & !exc_cancel & mdu_op in 1..4 & state==IDLE
- busy  output  1  registered: high while an operation is in flight
- mdu_stall  output  1  combinational: D_md_use & (start | busy)
- hi  output  32  HI register
- lo  output  32  LO register
- mdu_out  output  32  combinational: hi for op 5, lo for op 6, else 0

Behaviour:
- Reset (reset==0, asynchronous): state IDLE, busy=0, counter=0, hi=lo=0, pending registers 0. Resetting mid-operation discards the operation; no HI/LO write ever follows.
- States: IDLE, RUN.
- IDLE -> RUN on the edge where start=1:
  - latch the pending HI/LO result computed from rs_val/rt_val;
  - load the counter with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4);
  - busy=1 from the following cycle.
- RUN:
  - counter decrements each edge;
  - on the edge where counter==1: write the pending result to hi/lo, busy<=0, go to IDLE.
- Latency: hi/lo change exactly N rising edges after the start edge (N = MULT_CYCLES or DIV_CYCLES). busy is high for exactly N cycles. A new start is accepted in the cycle busy is low again.
- Arithmetic:
  - mult: signed 32x32 -> 64; HI=[63:32], LO=[31:0].
  - multu: same, unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with sign of the dividend (rs/rt signed). 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned quotient/remainder.
  - Divisor rt==0 (div or divu): the full N-cycle busy sequence still runs; at completion hi/lo are left unchanged.
- mthi/mtlo: when op_valid & !exc_cancel & state==IDLE, hi (op 7) or lo (op 8) <= rs_val on the edge.
- mfhi/mflo: read current hi/lo combinationally, with no side effects.
- exc_cancel=1 suppresses start and mthi/mtlo in that cycle. It does not abort an operation already in RUN; that operation completes normally.
- Any op 1-4, 7 or 8 presented while state==RUN is ignored (protocol violation; the hazard unit prevents it via mdu_stall). hi/lo and the counter are unaffected.
- mdu_stall covers the start cycle as well as the busy cycles, so a D-stage MDU instruction directly behind a starting mult/div is held.

Test Plan:
- mult rs=0xFFFFFFFD, rt=5, op_valid=1 -> start=1 for one cycle; busy high 5 cycles; after the 5th edge HI=0xFFFFFFFF, LO=0xFFFFFFF1; mdu_stall=1 with D_md_use=1 during start/busy, 0 after.
- divu rs=100, rt=7 -> busy 10 cycles, then LO=0x0000000E, HI=0x00000002. div rs=0xFFFFFFF9, rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Prior state HI=0x11, LO=0x22; div rs=5, rt=0 -> busy 10 cycles, HI=0x11, LO=0x22 afterwards. Then mfhi -> mdu_out=0x11; mflo -> 0x22.
- mthi rs=0xABCD with exc_cancel=1 -> hi unchanged, start=0. Repeat with exc_cancel=0 -> hi=0xABCD next edge. mult with exc_cancel=1 -> busy stays 0.
- Start multu 0xFFFFFFFF*2, assert exc_cancel on cycle 2 of RUN -> still completes: HI=0x1, LO=0xFFFFFFFE. Present mtlo during RUN -> lo unaffected by it.
- Start div, drive reset low at cycle 4 of RUN -> busy=0, hi=lo=0 immediately; after release, no late HI/LO write occurs.
